// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the FIFO drain arbiter.
// Round-robin search helper operates on up to 16 requesters.
package fifo_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_BURST = 2'd1,
    ARB_DRAIN = 2'd2
  } arb_state_t;

  localparam int MAX_SRC = 16;

  typedef struct packed {
    logic       found;
    logic [3:0] idx;
  } rr_pick_t;

  // First set bit of req strictly after ptr, wrapping modulo n.
  function automatic rr_pick_t rr_next(
    input logic [MAX_SRC-1:0] req,
    input logic [3:0]         ptr,
    input int                 n = MAX_SRC
  );
    rr_pick_t r;
    int       k;
    r = '0;
    for (int s = 1; s <= MAX_SRC; s++) begin
      k = (int'(ptr) + s) % n;
      if (!r.found && s <= n && req[k]) begin
        r.found = 1'b1;
        r.idx   = 4'(k);
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/sync_skid_fifo.sv
// Single-clock first-word-fall-through buffer with occupancy count.
// Push and pop may coincide at any occupancy, including full.
module sync_skid_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           din,
  input  logic                       pop,
  output logic [WIDTH-1:0]           dout,
  output logic                       valid,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_q, wr_d;
  logic [PW-1:0]    rd_q, rd_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign do_pop  = pop && (cnt_q != '0);
  assign do_push = push && ((cnt_q != CW'(DEPTH)) || do_pop);

  always_comb begin
    wr_d  = do_push ? ptr_inc(wr_q) : wr_q;
    rd_d  = do_pop ? ptr_inc(rd_q) : rd_q;
    cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_q] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  assign dout  = mem[rd_q];
  assign valid = (cnt_q != '0);
  assign count = cnt_q;

endmodule

// File: rtl/fifo_drain_arbiter.sv
// Round-robin burst drain of several FIFO read ports into one
// tagged ready/valid stream, credit-limited by a local skid buffer.
module fifo_drain_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NUM_SRC    = 4,
  parameter int ADDR_WIDTH = 13,
  parameter int DATA_WIDTH = 16,
  parameter int BURST_LEN  = 8,
  parameter int SKID_DEPTH = 8
) (
  input  logic                               oclk,
  input  logic                               oreset_n,
  input  logic [NUM_SRC*(ADDR_WIDTH+1)-1:0]  src_full_count,
  input  logic [NUM_SRC*DATA_WIDTH-1:0]      src_data,
  input  logic [NUM_SRC-1:0]                 src_data_valid,
  output logic [NUM_SRC-1:0]                 src_rd,
  input  logic                               flush,
  output logic [DATA_WIDTH-1:0]              out_data,
  output logic [$clog2(NUM_SRC)-1:0]         out_src,
  output logic                               out_last,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic                               busy,
  output logic                               err_stray
);

  localparam int CW = ADDR_WIDTH + 1;
  localparam int SW = $clog2(NUM_SRC);
  localparam int OW = $clog2(SKID_DEPTH + 1);
  localparam int EW = DATA_WIDTH + SW + 1;

  arb_state_t      state_q, state_d;
  logic [SW-1:0]   grant_q, grant_d;
  logic [SW-1:0]   rr_q, rr_d;
  logic [CW-1:0]   rem_q, rem_d;
  logic [OW-1:0]   out_q, out_d;
  logic            live_q;
  logic            err_q;

  logic [CW-1:0]      fcnt [NUM_SRC];
  logic [NUM_SRC-1:0] elig;
  rr_pick_t           pick;
  logic [SW-1:0]      pick_idx;
  logic [CW-1:0]      pick_cnt;

  logic [OW-1:0]      skid_cnt;
  logic [OW:0]        inflight;
  logic               issue;
  logic [NUM_SRC-1:0] gnt_oh;
  logic               ret;
  logic               ret_last;
  logic [DATA_WIDTH-1:0] ret_data;
  logic               stray;

  logic [EW-1:0]      skid_din;
  logic [EW-1:0]      skid_dout;
  logic               skid_valid;

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_elig
    assign fcnt[g] = src_full_count[g*CW +: CW];
    assign elig[g] = (fcnt[g] >= CW'(BURST_LEN)) ||
                     (flush && (fcnt[g] != '0));
  end

  assign pick     = rr_next(16'(elig), 4'(rr_q), NUM_SRC);
  assign pick_idx = SW'(pick.idx);
  assign pick_cnt = fcnt[pick_idx];

  // Credit: every issued read already owns a skid slot.
  assign inflight = (OW+1)'(skid_cnt) + (OW+1)'(out_q);
  assign issue    = (state_q == ARB_BURST) && (rem_q != '0) &&
                    (inflight < (OW+1)'(SKID_DEPTH));
  assign gnt_oh   = NUM_SRC'(1) << grant_q;
  assign src_rd   = issue ? gnt_oh : '0;

  assign ret      = src_data_valid[grant_q] && (out_q != '0);
  assign ret_last = ret && (rem_q == '0) && (out_q == OW'(1));
  assign ret_data = src_data[grant_q*DATA_WIDTH +: DATA_WIDTH];
  assign stray    = |(src_data_valid & ~(ret ? gnt_oh : '0));

  assign out_d = out_q + OW'(issue) - OW'(ret);

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    rr_d    = rr_q;
    rem_d   = rem_q;
    unique case (1'b1)
      state_q == ARB_IDLE: begin
        if (live_q && pick.found) begin
          grant_d = pick_idx;
          rr_d    = pick_idx;
          rem_d   = (pick_cnt < CW'(BURST_LEN)) ?
                    pick_cnt : CW'(BURST_LEN);
          state_d = ARB_BURST;
        end
      end
      state_q == ARB_BURST: begin
        if (issue) begin
          rem_d = rem_q - 1'b1;
          if (rem_q == CW'(1)) state_d = ARB_DRAIN;
        end
      end
      default: begin
        if (out_d == '0) state_d = ARB_IDLE;
      end
    endcase
  end

  always_ff @(posedge oclk or negedge oreset_n) begin
    if (!oreset_n) begin
      state_q <= ARB_IDLE;
      grant_q <= '0;
      rr_q    <= SW'(NUM_SRC - 1);
      rem_q   <= '0;
      out_q   <= '0;
      live_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      rr_q    <= rr_d;
      rem_q   <= rem_d;
      out_q   <= out_d;
      live_q  <= 1'b1;
      err_q   <= stray;
    end
  end

  assign skid_din = {ret_data, grant_q, ret_last};

  sync_skid_fifo #(
    .DEPTH (SKID_DEPTH),
    .WIDTH (EW)
  ) u_skid (
    .clk   (oclk),
    .rst_n (oreset_n),
    .push  (ret),
    .din   (skid_din),
    .pop   (out_valid && out_ready),
    .dout  (skid_dout),
    .valid (skid_valid),
    .count (skid_cnt)
  );

  assign out_valid = skid_valid;
  assign out_data  = skid_valid ? skid_dout[EW-1 -: DATA_WIDTH] : '0;
  assign out_src   = skid_valid ? skid_dout[SW:1] : '0;
  assign out_last  = skid_valid && skid_dout[0];
  assign busy      = (state_q != ARB_IDLE) || skid_valid;
  assign err_stray = err_q;

endmodule

// File: tb/tb_fifo_drain_arbiter.sv
// Bench for fifo_drain_arbiter: FIFO read-port models plus a
// burst-level scoreboard of the expected merged output stream.
module tb_fifo_drain_arbiter;

  localparam int NS = 4;
  localparam int AW = 13;
  localparam int DW = 16;
  localparam int BL = 8;
  localparam int SD = 8;
  localparam int CW = AW + 1;
  localparam int SW = 2;

  logic              oclk = 1'b0;
  logic              oreset_n = 1'b0;
  logic [NS*CW-1:0]  src_full_count = '0;
  logic [NS*DW-1:0]  src_data = '0;
  logic [NS-1:0]     src_data_valid = '0;
  logic [NS-1:0]     src_rd;
  logic              flush = 1'b0;
  logic [DW-1:0]     out_data;
  logic [SW-1:0]     out_src;
  logic              out_last;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic              busy;
  logic              err_stray;

  always #5 oclk = ~oclk;

  fifo_drain_arbiter #(
    .NUM_SRC    (NS),
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .BURST_LEN  (BL),
    .SKID_DEPTH (SD)
  ) dut (
    .oclk           (oclk),
    .oreset_n       (oreset_n),
    .src_full_count (src_full_count),
    .src_data       (src_data),
    .src_data_valid (src_data_valid),
    .src_rd         (src_rd),
    .flush          (flush),
    .out_data       (out_data),
    .out_src        (out_src),
    .out_last       (out_last),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .busy           (busy),
    .err_stray      (err_stray)
  );

  int errs = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  typedef struct { int due; int src; int data; } ret_t;
  typedef struct { int data; int src; bit last; } word_t;

  ret_t  rq[$];
  word_t exq[$];

  int fcnt[NS];
  int fhead[NS];
  bit drv_flush;
  int rdy_pct;
  int lat;
  int cyc;
  int issued;
  int accepted;
  int strays;
  bit inj3;
  int first_src;

  int m_rr;
  int m_cnt[NS];
  int m_head[NS];

  function automatic int fdat(input int s, input int q);
    return (s << 12) | (q & 'hfff);
  endfunction

  // Burst-level reference: whole grant sequence from counts alone.
  function automatic void model_plan();
    int  i;
    int  n;
    bit  hit;
    forever begin
      hit = 0;
      i = 0;
      for (int k = 1; k <= NS; k++) begin
        int c;
        c = (m_rr + k) % NS;
        if (!hit && (m_cnt[c] >= BL || (drv_flush && m_cnt[c] > 0))) begin
          hit = 1;
          i = c;
        end
      end
      if (!hit) break;
      n = (m_cnt[i] < BL) ? m_cnt[i] : BL;
      for (int j = 0; j < n; j++)
        exq.push_back('{fdat(i, m_head[i] + j), i, j == n - 1});
      m_head[i] += n;
      m_cnt[i]  -= n;
      m_rr = i;
    end
  endfunction

  task automatic step();
    ret_t  r;
    word_t e;
    @(posedge oclk);
    #1;
    cyc++;
    src_data_valid = '0;
    src_data = {NS{16'($urandom)}};
    while (rq.size() > 0 && rq[0].due == cyc) begin
      r = rq.pop_front();
      src_data_valid[r.src] = 1'b1;
      src_data[r.src*DW +: DW] = DW'(r.data);
    end
    if (inj3) begin
      src_data_valid[3] = 1'b1;
      inj3 = 0;
    end
    for (int i = 0; i < NS; i++) src_full_count[i*CW +: CW] = CW'(fcnt[i]);
    flush = drv_flush;
    out_ready = ($urandom_range(0, 99) < rdy_pct);
    #1;
    if (err_stray) strays++;
    chk("rd_onehot", 32'($onehot0(src_rd)), 1);
    for (int i = 0; i < NS; i++) begin
      if (src_rd[i]) begin
        chk("rd_avail", 32'(fcnt[i] > 0), 1);
        fcnt[i]--;
        rq.push_back('{cyc + lat, i, fdat(i, fhead[i])});
        fhead[i]++;
        issued++;
      end
    end
    if (out_valid && out_ready) begin
      accepted++;
      if (first_src < 0) first_src = int'(out_src);
      if (exq.size() == 0) begin
        chk("extra_word", 1, 0);
      end else begin
        e = exq.pop_front();
        chk("out_data", 32'(out_data), e.data);
        chk("out_src", 32'(out_src), e.src);
        chk("out_last", 32'(out_last), 32'(e.last));
      end
    end
    chk("credit", 32'((issued - accepted) <= SD), 1);
  endtask

  task automatic scn_start(input int a0, input int a1, input int a2,
                           input int a3, input bit fl, input int pct,
                           input int l);
    fcnt[0] += a0;
    fcnt[1] += a1;
    fcnt[2] += a2;
    fcnt[3] += a3;
    drv_flush = fl;
    rdy_pct = pct;
    lat = l;
    issued = 0;
    accepted = 0;
    m_cnt = fcnt;
    m_head = fhead;
    model_plan();
  endtask

  task automatic scn_finish(input string tag, input int exp_str);
    for (int k = 0; k < 4000; k++) begin
      step();
      if (k >= 20 && exq.size() == 0 && rq.size() == 0 && !busy) break;
    end
    repeat (8) step();
    chk({tag, "_left"}, 32'(exq.size()), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_stray"}, 32'(strays), exp_str);
    strays = 0;
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_rd"}, 32'(src_rd), 0);
    chk({tag, "_valid"}, 32'(out_valid), 0);
    chk({tag, "_last"}, 32'(out_last), 0);
    chk({tag, "_src"}, 32'(out_src), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_err"}, 32'(err_stray), 0);
  endtask

  initial begin
    logic [DW-1:0] held;
    int            n0;
    for (int i = 0; i < NS; i++) begin
      fcnt[i] = 0;
      fhead[i] = 0;
    end
    drv_flush = 0;
    rdy_pct = 100;
    lat = 2;
    cyc = 0;
    issued = 0;
    accepted = 0;
    strays = 0;
    inj3 = 0;
    first_src = -1;
    m_rr = NS - 1;

    repeat (2) @(posedge oclk);
    #1;
    chk_reset_outs("rst");
    oreset_n = 1'b1;

    scn_start(0, 0, 0, 0, 0, 100, 2);
    scn_finish("zero", 0);

    scn_start(0, 0, 20, 0, 0, 100, 2);
    scn_finish("src2", 0);

    scn_start(100, 100, 100, 100, 0, 100, 1);
    scn_finish("all100", 0);

    scn_start(0, 3, 0, 0, 0, 100, 2);
    scn_finish("noflush", 0);
    scn_start(0, 0, 0, 0, 1, 100, 2);
    scn_finish("flush", 0);

    scn_start(0, 0, 20, 0, 0, 0, 2);
    n0 = issued;
    repeat (20) step();
    held = out_data;
    repeat (20) step();
    chk("stall_issued", 32'(issued - n0), SD);
    chk("stall_rd", 32'(src_rd), 0);
    chk("stall_valid", 32'(out_valid), 1);
    chk("stall_hold", 32'(out_data), 32'(held));
    rdy_pct = 100;
    scn_finish("stall", 0);

    scn_start(20, 0, 0, 0, 0, 100, 2);
    for (int k = 0; k < 50; k++) begin
      step();
      if (src_rd[0]) break;
    end
    inj3 = 1;
    scn_finish("stray", 1);

    scn_start(100, 100, 100, 100, 0, 70, 2);
    repeat (15) step();
    oreset_n = 1'b0;
    #1;
    chk_reset_outs("midrst");
    rq.delete();
    exq.delete();
    inj3 = 0;
    m_rr = NS - 1;
    repeat (2) step();
    oreset_n = 1'b1;
    first_src = -1;
    scn_start(0, 0, 0, 0, 1, 80, 3);
    scn_finish("postrst", 0);
    chk("postrst_first", 32'(first_src), 0);

    for (int t = 0; t < 25; t++) begin
      scn_start($urandom_range(0, 24), $urandom_range(0, 24),
                $urandom_range(0, 24), $urandom_range(0, 24),
                $urandom_range(0, 2) == 0, $urandom_range(30, 100),
                $urandom_range(1, 3));
      scn_finish("rand", 0);
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
